// File: rtl/mux_scan_serializer.sv
// ---------------------------------------------------------------------------
// mux_scan_serializer
//
// Sequencer and output register for the 16:1 channel mux in the CNN
// datapath. A start pulse launches a scan that walks the mux select through
// channels 0..NUM_CH-1. Each selected word is captured into a one-deep
// output register and offered as a valid/ready stream, tagged with its
// channel index. The word from the final channel carries a last flag. Once
// that last word has been accepted, done pulses for one cycle and the
// block returns to idle.
//
// Parameters
//   WIDTH     mux data width and output word width
//   NUM_CH    channels scanned per run (1..16)
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   start      in   one-cycle scan request, honoured only when idle
//   sel        out  mux select, upper nibble always zero
//   mux_data   in   mux output, combinational from sel
//   out_data   out  captured word
//   out_ch     out  channel index of out_data
//   out_last   out  out_data came from channel NUM_CH-1
//   out_valid  out  out_data/out_ch/out_last are valid
//   out_ready  in   consumer accepts the word
//   busy       out  scan in progress (state is not IDLE)
//   done       out  one-cycle pulse after the last word is accepted
// ---------------------------------------------------------------------------
module mux_scan_serializer #(
   parameter int WIDTH  = 16,
   parameter int NUM_CH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [7:0]       sel,
   input  logic [WIDTH-1:0] mux_data,
   output logic [WIDTH-1:0] out_data,
   output logic [3:0]       out_ch,
   output logic             out_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [3:0] LAST_CH = 4'(NUM_CH - 1);

   state_t     state_reg;
   logic [3:0] ch_reg;
   logic       load;
   logic       xfer;

   // The output register refills whenever it is empty or being emptied on
   // this edge, so an uninterrupted scan streams one word per cycle.
   assign load = (state_reg == SCAN) && (!out_valid || out_ready);
   assign xfer = out_valid && out_ready;

   // The mux sees the counter directly; mux_data settles within the cycle
   // and is captured on the next edge.
   assign sel  = {4'b0000, ch_reg};
   assign busy = (state_reg != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         ch_reg    <= 4'd0;
         out_data  <= '0;
         out_ch    <= 4'd0;
         out_last  <= 1'b0;
         out_valid <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_reg)
            IDLE: begin
               ch_reg <= 4'd0;
               if (start) begin
                  state_reg <= SCAN;
               end
            end

            SCAN: begin
               // Under backpressure (valid && !ready) nothing changes, which
               // keeps sel frozen and the presented word stable.
               if (load) begin
                  out_data  <= mux_data;
                  out_ch    <= ch_reg;
                  out_last  <= (ch_reg == LAST_CH);
                  out_valid <= 1'b1;
                  if (ch_reg == LAST_CH) begin
                     state_reg <= DRAIN;
                  end else begin
                     ch_reg <= ch_reg + 4'd1;
                  end
               end
            end

            DRAIN: begin
               // Only the last word is left in the register; nothing reloads,
               // so the transfer empties it and ends the run.
               if (xfer) begin
                  out_valid <= 1'b0;
                  done      <= 1'b1;
                  ch_reg    <= 4'd0;
                  state_reg <= IDLE;
               end
            end

            default: begin
               state_reg <= IDLE;
               ch_reg    <= 4'd0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux_scan_serializer.sv
// ---------------------------------------------------------------------------
// Self-checking bench for mux_scan_serializer. Stimulus pushes the expected
// words of each scan into a queue; independent monitors pop and compare on
// every accepted word and police the done pulse.
// ---------------------------------------------------------------------------
module tb_mux_scan_serializer;

   typedef struct {
      logic [15:0] d;
      logic [3:0]  c;
      logic        l;
   } word_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  sel;
   logic [15:0] mux_data;
   logic [15:0] out_data;
   logic [3:0]  out_ch;
   logic        out_last;
   logic        out_valid;
   logic        out_ready;
   logic        busy;
   logic        done;

   // Second instance with a single channel.
   logic        start1;
   logic [7:0]  sel1;
   logic [15:0] mux_data1;
   logic [15:0] out_data1;
   logic [3:0]  out_ch1;
   logic        out_last1;
   logic        out_valid1;
   logic        out_ready1;
   logic        busy1;
   logic        done1;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int last_edge = -1;
   int done_cnt  = 0;
   int busy_cnt  = 0;
   int words     = 0;
   int done1_cnt = 0;
   word_t q[$];
   word_t q1[$];

   always #5 clk = ~clk;

   // Mux model: channel k presents 16'h1000 + k.
   assign mux_data  = 16'h1000 + {8'h00, sel};
   assign mux_data1 = 16'h1000 + {8'h00, sel1};

   mux_scan_serializer #(.WIDTH(16), .NUM_CH(16)) u_dut (
      .clk(clk), .rst(rst), .start(start), .sel(sel), .mux_data(mux_data),
      .out_data(out_data), .out_ch(out_ch), .out_last(out_last),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
   );

   mux_scan_serializer #(.WIDTH(16), .NUM_CH(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .sel(sel1), .mux_data(mux_data1),
      .out_data(out_data1), .out_ch(out_ch1), .out_last(out_last1),
      .out_valid(out_valid1), .out_ready(out_ready1), .busy(busy1), .done(done1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor for the 16-channel instance. A word seen valid&&ready here is
   // transferred on the following rising edge (edge number cyc+1).
   always @(negedge clk) begin
      word_t w;
      if (busy) busy_cnt++;
      if (!rst && out_valid && out_ready) begin
         if (q.size() == 0) begin
            chk("unexpected_word", {12'h0, out_ch, out_data}, 32'hFFFF_FFFF);
         end else begin
            w = q.pop_front();
            chk("out_data", {16'h0, out_data}, {16'h0, w.d});
            chk("out_ch", {28'h0, out_ch}, {28'h0, w.c});
            chk("out_last", {31'h0, out_last}, {31'h0, w.l});
            words++;
            $display("xfer ch=%0d data=%h last=%0b", out_ch, out_data, out_last);
            if (w.l) last_edge = cyc + 1;
         end
      end
      if (!rst && done) begin
         // done must be high exactly in the cycle after the last transfer.
         chk("done_timing", cyc, last_edge);
         done_cnt++;
      end
   end

   // Monitor for the single-channel instance.
   always @(negedge clk) begin
      word_t w;
      if (!rst && out_valid1 && out_ready1) begin
         if (q1.size() == 0) begin
            chk("n1_unexpected_word", {12'h0, out_ch1, out_data1}, 32'hFFFF_FFFF);
         end else begin
            w = q1.pop_front();
            chk("n1_out_data", {16'h0, out_data1}, {16'h0, w.d});
            chk("n1_out_ch", {28'h0, out_ch1}, {28'h0, w.c});
            chk("n1_out_last", {31'h0, out_last1}, {31'h0, w.l});
            $display("n1 xfer ch=%0d data=%h last=%0b", out_ch1, out_data1, out_last1);
         end
      end
      if (!rst && done1) done1_cnt++;
   end

   task automatic push_scan();
      word_t w;
      for (int k = 0; k < 16; k++) begin
         w.d = 16'h1000 + 16'(k);
         w.c = 4'(k);
         w.l = (k == 15);
         q.push_back(w);
      end
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   // Runs until one more done is seen. rnd randomises out_ready; poke holds
   // start high whenever the block is busy (it must be ignored).
   task automatic run_until_done(input bit rnd, input bit poke);
      int prev = done_cnt;
      int n = 0;
      while (done_cnt == prev && n < 3000) begin
         @(posedge clk); #1;
         if (rnd) out_ready = 1'($urandom_range(0, 1));
         if (poke) start = busy;
         n++;
      end
      start = 1'b0;
      out_ready = 1'b1;
      if (done_cnt == prev) chk("done_timeout", 32'(n), 32'hFFFF_FFFF);
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_out_valid"}, {31'h0, out_valid}, 32'h0);
      chk({tag, "_out_data"}, {16'h0, out_data}, 32'h0);
      chk({tag, "_out_ch"}, {28'h0, out_ch}, 32'h0);
      chk({tag, "_out_last"}, {31'h0, out_last}, 32'h0);
      chk({tag, "_done"}, {31'h0, done}, 32'h0);
      chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
      chk({tag, "_sel"}, {24'h0, sel}, 32'h0);
   endtask

   initial begin
      int prev;
      int n;
      word_t w;
      rst = 1'b1; start = 1'b0; out_ready = 1'b1;
      start1 = 1'b0; out_ready1 = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_idle("reset");

      // Full scan, no backpressure.
      push_scan();
      busy_cnt = 0;
      prev = done_cnt;
      pulse_start();
      run_until_done(1'b0, 1'b0);
      repeat (3) @(posedge clk);
      chk("scan1_busy_cycles", 32'(busy_cnt), 32'd17);
      chk("scan1_done_count", 32'(done_cnt - prev), 32'd1);
      chk("scan1_queue_empty", 32'(q.size()), 32'd0);

      // Backpressure on channel 3 for 5 cycles.
      push_scan();
      pulse_start();
      n = 0;
      while (!(out_valid && out_ch == 4'd3) && n < 100) begin
         @(posedge clk); #1; n++;
      end
      chk("bp_reached_ch3", {31'h0, out_valid}, 32'h1);
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_out_data", {16'h0, out_data}, 32'h1003);
         chk("bp_out_ch", {28'h0, out_ch}, 32'h3);
         chk("bp_sel", {24'h0, sel}, 32'h4);
         chk("bp_out_valid", {31'h0, out_valid}, 32'h1);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      run_until_done(1'b0, 1'b0);
      chk("bp_queue_empty", 32'(q.size()), 32'd0);

      // 20 scans with random ready.
      for (int s = 0; s < 20; s++) begin
         push_scan();
         prev = done_cnt;
         pulse_start();
         run_until_done(1'b1, 1'b0);
         repeat (2) @(posedge clk);
         chk("rand_done_count", 32'(done_cnt - prev), 32'd1);
         chk("rand_queue_empty", 32'(q.size()), 32'd0);
      end

      // start held high throughout SCAN and DRAIN must be ignored.
      push_scan();
      prev = done_cnt;
      words = 0;
      pulse_start();
      run_until_done(1'b0, 1'b1);
      repeat (20) @(posedge clk);
      chk("ign_words", 32'(words), 32'd16);
      chk("ign_done_count", 32'(done_cnt - prev), 32'd1);
      chk("ign_busy_after", {31'h0, busy}, 32'h0);

      // Single-channel instance.
      w.d = 16'h1000; w.c = 4'd0; w.l = 1'b1;
      q1.push_back(w);
      @(posedge clk); #1 start1 = 1'b1;
      @(posedge clk); #1 start1 = 1'b0;
      repeat (5) @(posedge clk);
      chk("n1_queue_empty", 32'(q1.size()), 32'd0);
      chk("n1_done_count", 32'(done1_cnt), 32'd1);
      chk("n1_busy_after", {31'h0, busy1}, 32'h0);

      // Reset mid-scan with channel 7 pending.
      push_scan();
      pulse_start();
      n = 0;
      while (!(out_valid && out_ch == 4'd7) && n < 100) begin
         @(posedge clk); #1; n++;
      end
      chk("rst_reached_ch7", {31'h0, out_valid}, 32'h1);
      out_ready = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      check_idle("midrst");
      q.delete();
      rst = 1'b0;
      out_ready = 1'b1;
      push_scan();
      prev = done_cnt;
      pulse_start();
      run_until_done(1'b0, 1'b0);
      repeat (2) @(posedge clk);
      chk("rescan_done_count", 32'(done_cnt - prev), 32'd1);
      chk("rescan_queue_empty", 32'(q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
